// File: rtl/inst_encoder.sv
// RV32I instruction encoder: turns a one-hot inst_* code plus operand fields into a
// machine word, tags it with a word address and queues it in a small output FIFO.
module inst_encoder #(
  parameter int                 N_param    = 32,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [N_param-1:0] BASE_ADDR  = '0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [63:0]                   i_inst,
  input  logic [4:0]                    i_rd,
  input  logic [4:0]                    i_rs1,
  input  logic [4:0]                    i_rs2,
  input  logic [31:0]                   i_imm,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [N_param-1:0]            o_instruction,
  output logic [N_param-1:0]            o_addr,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_illegal,
  output logic [15:0]                   o_illegal_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  // One-hot instruction codes shared with the decoder; bits 48..63 are unmapped.
  localparam logic [63:0] INST_LUI   = 64'h1 << 0,  INST_AUIPC  = 64'h1 << 1;
  localparam logic [63:0] INST_JAL   = 64'h1 << 2,  INST_JALR   = 64'h1 << 3;
  localparam logic [63:0] INST_BEQ   = 64'h1 << 4,  INST_BNE    = 64'h1 << 5;
  localparam logic [63:0] INST_BLT   = 64'h1 << 6,  INST_BGE    = 64'h1 << 7;
  localparam logic [63:0] INST_BLTU  = 64'h1 << 8,  INST_BGEU   = 64'h1 << 9;
  localparam logic [63:0] INST_LB    = 64'h1 << 10, INST_LH     = 64'h1 << 11;
  localparam logic [63:0] INST_LW    = 64'h1 << 12, INST_LBU    = 64'h1 << 13;
  localparam logic [63:0] INST_LHU   = 64'h1 << 14, INST_SB     = 64'h1 << 15;
  localparam logic [63:0] INST_SH    = 64'h1 << 16, INST_SW     = 64'h1 << 17;
  localparam logic [63:0] INST_ADDI  = 64'h1 << 18, INST_SLTI   = 64'h1 << 19;
  localparam logic [63:0] INST_SLTIU = 64'h1 << 20, INST_XORI   = 64'h1 << 21;
  localparam logic [63:0] INST_ORI   = 64'h1 << 22, INST_ANDI   = 64'h1 << 23;
  localparam logic [63:0] INST_SLLI  = 64'h1 << 24, INST_SRLI   = 64'h1 << 25;
  localparam logic [63:0] INST_SRAI  = 64'h1 << 26, INST_ADD    = 64'h1 << 27;
  localparam logic [63:0] INST_SUB   = 64'h1 << 28, INST_SLL    = 64'h1 << 29;
  localparam logic [63:0] INST_SLT   = 64'h1 << 30, INST_SLTU   = 64'h1 << 31;
  localparam logic [63:0] INST_XOR   = 64'h1 << 32, INST_SRL    = 64'h1 << 33;
  localparam logic [63:0] INST_SRA   = 64'h1 << 34, INST_OR     = 64'h1 << 35;
  localparam logic [63:0] INST_AND   = 64'h1 << 36, INST_FENCE  = 64'h1 << 37;
  localparam logic [63:0] INST_FENCE_I = 64'h1 << 38, INST_ECALL = 64'h1 << 39;
  localparam logic [63:0] INST_EBREAK = 64'h1 << 40, INST_CSRRW  = 64'h1 << 41;
  localparam logic [63:0] INST_CSRRS  = 64'h1 << 42, INST_CSRRC  = 64'h1 << 43;
  localparam logic [63:0] INST_CSRRWI = 64'h1 << 44, INST_CSRRSI = 64'h1 << 45;
  localparam logic [63:0] INST_CSRRCI = 64'h1 << 46;

  typedef enum logic [3:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CONST
  } fmt_e;

  fmt_e        fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] constWord;
  logic [31:0] encWord;
  logic        legal;

  // Any code that is not exactly one recognised instruction (zero, multi-hot,
  // UNKNOWN, unmapped) falls to the default and is rejected.
  always_comb begin
    fmt = FMT_NONE; opcode = '0; funct3 = '0; funct7 = '0; constWord = '0;
    case (i_inst)
      INST_LUI:     begin fmt = FMT_U; opcode = 7'b0110111; end
      INST_AUIPC:   begin fmt = FMT_U; opcode = 7'b0010111; end
      INST_JAL:     begin fmt = FMT_J; opcode = 7'b1101111; end
      INST_JALR:    begin fmt = FMT_I; opcode = 7'b1100111; funct3 = 3'b000; end
      INST_BEQ:     begin fmt = FMT_B; opcode = 7'b1100011; funct3 = 3'b000; end
      INST_BNE:     begin fmt = FMT_B; opcode = 7'b1100011; funct3 = 3'b001; end
      INST_BLT:     begin fmt = FMT_B; opcode = 7'b1100011; funct3 = 3'b100; end
      INST_BGE:     begin fmt = FMT_B; opcode = 7'b1100011; funct3 = 3'b101; end
      INST_BLTU:    begin fmt = FMT_B; opcode = 7'b1100011; funct3 = 3'b110; end
      INST_BGEU:    begin fmt = FMT_B; opcode = 7'b1100011; funct3 = 3'b111; end
      INST_LB:      begin fmt = FMT_I; opcode = 7'b0000011; funct3 = 3'b000; end
      INST_LH:      begin fmt = FMT_I; opcode = 7'b0000011; funct3 = 3'b001; end
      INST_LW:      begin fmt = FMT_I; opcode = 7'b0000011; funct3 = 3'b010; end
      INST_LBU:     begin fmt = FMT_I; opcode = 7'b0000011; funct3 = 3'b100; end
      INST_LHU:     begin fmt = FMT_I; opcode = 7'b0000011; funct3 = 3'b101; end
      INST_SB:      begin fmt = FMT_S; opcode = 7'b0100011; funct3 = 3'b000; end
      INST_SH:      begin fmt = FMT_S; opcode = 7'b0100011; funct3 = 3'b001; end
      INST_SW:      begin fmt = FMT_S; opcode = 7'b0100011; funct3 = 3'b010; end
      INST_ADDI:    begin fmt = FMT_I; opcode = 7'b0010011; funct3 = 3'b000; end
      INST_SLTI:    begin fmt = FMT_I; opcode = 7'b0010011; funct3 = 3'b010; end
      INST_SLTIU:   begin fmt = FMT_I; opcode = 7'b0010011; funct3 = 3'b011; end
      INST_XORI:    begin fmt = FMT_I; opcode = 7'b0010011; funct3 = 3'b100; end
      INST_ORI:     begin fmt = FMT_I; opcode = 7'b0010011; funct3 = 3'b110; end
      INST_ANDI:    begin fmt = FMT_I; opcode = 7'b0010011; funct3 = 3'b111; end
      INST_SLLI:    begin fmt = FMT_SH; opcode = 7'b0010011; funct3 = 3'b001; end
      INST_SRLI:    begin fmt = FMT_SH; opcode = 7'b0010011; funct3 = 3'b101; end
      INST_SRAI:    begin fmt = FMT_SH; opcode = 7'b0010011; funct3 = 3'b101; funct7 = 7'b0100000; end
      INST_ADD:     begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b000; end
      INST_SUB:     begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000; end
      INST_SLL:     begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b001; end
      INST_SLT:     begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b010; end
      INST_SLTU:    begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b011; end
      INST_XOR:     begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b100; end
      INST_SRL:     begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b101; end
      INST_SRA:     begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b101; funct7 = 7'b0100000; end
      INST_OR:      begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b110; end
      INST_AND:     begin fmt = FMT_R; opcode = 7'b0110011; funct3 = 3'b111; end
      INST_FENCE:   begin fmt = FMT_I; opcode = 7'b0001111; funct3 = 3'b000; end
      INST_FENCE_I: begin fmt = FMT_CONST; constWord = 32'h0000_100F; end
      INST_ECALL:   begin fmt = FMT_CONST; constWord = 32'h0000_0073; end
      INST_EBREAK:  begin fmt = FMT_CONST; constWord = 32'h0010_0073; end
      INST_CSRRW:   begin fmt = FMT_I; opcode = 7'b1110011; funct3 = 3'b001; end
      INST_CSRRS:   begin fmt = FMT_I; opcode = 7'b1110011; funct3 = 3'b010; end
      INST_CSRRC:   begin fmt = FMT_I; opcode = 7'b1110011; funct3 = 3'b011; end
      INST_CSRRWI:  begin fmt = FMT_I; opcode = 7'b1110011; funct3 = 3'b101; end
      INST_CSRRSI:  begin fmt = FMT_I; opcode = 7'b1110011; funct3 = 3'b110; end
      INST_CSRRCI:  begin fmt = FMT_I; opcode = 7'b1110011; funct3 = 3'b111; end
      default:      fmt = FMT_NONE;
    endcase
  end

  assign legal = (fmt != FMT_NONE);

  always_comb begin
    encWord = '0;
    case (fmt)
      FMT_R:     encWord = {funct7, i_rs2, i_rs1, funct3, i_rd, opcode};
      FMT_I:     encWord = {i_imm[11:0], i_rs1, funct3, i_rd, opcode};
      FMT_SH:    encWord = {funct7, i_imm[4:0], i_rs1, funct3, i_rd, opcode};
      FMT_S:     encWord = {i_imm[11:5], i_rs2, i_rs1, funct3, i_imm[4:0], opcode};
      FMT_B:     encWord = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, funct3,
                            i_imm[4:1], i_imm[11], opcode};
      FMT_U:     encWord = {i_imm[31:12], i_rd, opcode};
      FMT_J:     encWord = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, opcode};
      FMT_CONST: encWord = constWord;
      default:   encWord = '0;
    endcase
  end

  logic [N_param-1:0] addrMem_q [FIFO_DEPTH];
  logic [N_param-1:0] wordMem_q [FIFO_DEPTH];
  logic [PW-1:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [N_param-1:0] nextAddr_q, nextAddr_d;
  logic               illegal_q, illegal_d;
  logic [15:0]        illCnt_q, illCnt_d;
  logic               accept, push, pop;

  // Ready depends only on registered occupancy, so i_ready never reaches o_ready.
  assign o_ready = (count_q != FULL);
  assign o_valid = (count_q != '0);
  assign accept  = i_valid & o_ready;
  assign push    = accept & legal;
  assign pop     = o_valid & i_ready;

  always_comb begin
    wrPtr_d    = push ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d    = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
    nextAddr_d = push ? nextAddr_q + N_param'(4) : nextAddr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    illegal_d = accept & ~legal;
    illCnt_d  = (illegal_d && illCnt_q != 16'hFFFF) ? illCnt_q + 16'd1 : illCnt_q;
  end

  // Storage is cleared on reset so the head shows {BASE_ADDR, 0} until the first push.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      nextAddr_q <= BASE_ADDR;
      illegal_q  <= 1'b0;
      illCnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addrMem_q[i] <= BASE_ADDR;
        wordMem_q[i] <= '0;
      end
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      nextAddr_q <= nextAddr_d;
      illegal_q  <= illegal_d;
      illCnt_q   <= illCnt_d;
      if (push) begin
        addrMem_q[wrPtr_q] <= nextAddr_q;
        wordMem_q[wrPtr_q] <= N_param'(encWord);
      end
    end
  end

  assign o_instruction = wordMem_q[rdPtr_q];
  assign o_addr        = addrMem_q[rdPtr_q];
  assign o_count       = count_q;
  assign o_illegal     = illegal_q;
  assign o_illegal_cnt = illCnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed requests push expected {addr, word}
// into a queue; a negedge monitor pops and compares whenever the head is consumed.
module tb_inst_encoder;

  localparam logic [63:0] INST_LUI    = 64'h1 << 0;
  localparam logic [63:0] INST_JAL    = 64'h1 << 2;
  localparam logic [63:0] INST_BEQ    = 64'h1 << 4;
  localparam logic [63:0] INST_SW     = 64'h1 << 17;
  localparam logic [63:0] INST_ADDI   = 64'h1 << 18;
  localparam logic [63:0] INST_SRAI   = 64'h1 << 26;
  localparam logic [63:0] INST_ADD    = 64'h1 << 27;
  localparam logic [63:0] INST_SUB    = 64'h1 << 28;
  localparam logic [63:0] INST_EBREAK = 64'h1 << 40;
  localparam logic [63:0] INST_CSRRWI = 64'h1 << 44;
  localparam logic [63:0] INST_UNKNOWN = 64'h1 << 47;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [63:0] iInst = '0;
  logic [4:0]  iRd = '0, iRs1 = '0, iRs2 = '0;
  logic [31:0] iImm = '0;
  logic        oValid;
  logic        iReady = 1'b1;
  logic [31:0] oInstruction, oAddr;
  logic [2:0]  oCount;
  logic        oIllegal;
  logic [15:0] oIllegalCnt;

  int checkCount = 0;
  int failCount = 0;
  int illegalPulses = 0;
  logic [63:0] expQ [$];
  logic [63:0] expEntry;
  logic        stallSeen = 1'b0;
  logic [31:0] stallWord, stallAddr;

  always #5 clk = ~clk;

  inst_encoder #(.N_param(32), .FIFO_DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(iValid), .o_ready(oReady),
    .i_inst(iInst), .i_rd(iRd), .i_rs1(iRs1), .i_rs2(iRs2), .i_imm(iImm),
    .o_valid(oValid), .i_ready(iReady), .o_instruction(oInstruction),
    .o_addr(oAddr), .o_count(oCount), .o_illegal(oIllegal),
    .o_illegal_cnt(oIllegalCnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Waits (bounded) until the request is accepted; leaves i_valid high so calls chain back-to-back.
  task automatic applyStimulus(input logic [63:0] inst, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic legal,
                               input logic [31:0] expWord, input logic [31:0] expAddr);
    int waited = 0;
    iValid = 1'b1; iInst = inst; iRd = rd; iRs1 = rs1; iRs2 = rs2; iImm = imm;
    @(negedge clk);
    while (!oReady && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!oReady) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      iValid = 1'b0;
    end else begin
      if (legal) expQ.push_back({expAddr, expWord});
      @(posedge clk);
      #1;
      checkOutput("illegal_pulse", {63'd0, oIllegal}, {63'd0, ~legal});
    end
  endtask

  task automatic idle();
    iValid = 1'b0;
    iInst = '0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitDrain();
    int waited = 0;
    while (expQ.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    checkOutput("drain_remaining", 64'(expQ.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the head on every consumed cycle and checks head stability under stall.
  always @(negedge clk) begin
    if (rst) begin
      stallSeen <= 1'b0;
    end else begin
      if (stallSeen) begin
        checkOutput("stall_valid", {63'd0, oValid}, 64'd1);
        checkOutput("stall_word", {32'd0, oInstruction}, {32'd0, stallWord});
        checkOutput("stall_addr", {32'd0, oAddr}, {32'd0, stallAddr});
      end
      if (oValid && iReady) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", {32'd0, oInstruction}, 64'd0);
        end else begin
          expEntry = expQ.pop_front();
          checkOutput("head_word", {32'd0, oInstruction}, {32'd0, expEntry[31:0]});
          checkOutput("head_addr", {32'd0, oAddr}, {32'd0, expEntry[63:32]});
        end
      end
      stallSeen <= oValid && !iReady;
      stallWord <= oInstruction;
      stallAddr <= oAddr;
    end
  end

  always @(negedge clk) begin
    if (!rst && oIllegal) illegalPulses++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_valid", {63'd0, oValid}, 64'd0);
    checkOutput("rst_ready", {63'd0, oReady}, 64'd1);
    checkOutput("rst_count", {61'd0, oCount}, 64'd0);
    checkOutput("rst_addr", {32'd0, oAddr}, 64'd0);
    checkOutput("rst_word", {32'd0, oInstruction}, 64'd0);
    checkOutput("rst_illegal", {63'd0, oIllegal}, 64'd0);
    checkOutput("rst_illcnt", {48'd0, oIllegalCnt}, 64'd0);

    $display("[TB] formats");
    iReady = 1'b1;
    applyStimulus(INST_ADDI,   5'd1, 5'd0, 5'd0, 32'd5,        1'b1, 32'h0050_0093, 32'h00);
    applyStimulus(INST_SW,     5'd0, 5'd1, 5'd2, 32'd8,        1'b1, 32'h0020_A423, 32'h04);
    applyStimulus(INST_BEQ,    5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3, 32'h08);
    applyStimulus(INST_JAL,    5'd1, 5'd0, 5'd0, 32'd8,        1'b1, 32'h0080_00EF, 32'h0C);
    applyStimulus(INST_LUI,    5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7, 32'h10);
    applyStimulus(INST_EBREAK, 5'd0, 5'd0, 5'd0, 32'd0,        1'b1, 32'h0010_0073, 32'h14);
    applyStimulus(INST_SRAI,   5'd1, 5'd2, 5'd0, 32'h0000_0FE3, 1'b1, 32'h4031_5093, 32'h18);
    applyStimulus(INST_CSRRWI, 5'd1, 5'd5, 5'd0, 32'h0000_0305, 1'b1, 32'h3052_D0F3, 32'h1C);
    idle();
    waitDrain();

    $display("[TB] backpressure");
    resetDut();
    iReady = 1'b0;
    fork
      begin
        for (int k = 1; k <= 5; k++)
          applyStimulus(INST_ADDI, 5'd1, 5'd0, 5'd0, 32'(k), 1'b1,
                        (32'(k) << 20) | 32'h93, 32'(4 * (k - 1)));
        idle();
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        checkOutput("bp_ready_low", {63'd0, oReady}, 64'd0);
        checkOutput("bp_count_full", {61'd0, oCount}, 64'd4);
        iReady = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] illegal");
    resetDut();
    illegalPulses = 0;
    applyStimulus(INST_UNKNOWN,        5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'd0, 32'd0);
    applyStimulus(INST_ADD | INST_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'd0, 32'd0);
    applyStimulus(INST_ADD,            5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3, 32'h0);
    idle();
    waitDrain();
    checkOutput("illegal_pulses", 64'(illegalPulses), 64'd2);
    checkOutput("illegal_cnt", {48'd0, oIllegalCnt}, 64'd2);

    $display("[TB] push and pop");
    iReady = 1'b0;
    applyStimulus(INST_ADDI, 5'd2, 5'd0, 5'd0, 32'd1, 1'b1, 32'h0010_0113, 32'h04);
    applyStimulus(INST_ADDI, 5'd2, 5'd0, 5'd0, 32'd2, 1'b1, 32'h0020_0113, 32'h08);
    idle();
    checkOutput("pp_count_start", {61'd0, oCount}, 64'd2);
    iReady = 1'b1;
    for (int n = 0; n < 10; n++) begin
      applyStimulus(INST_ADDI, 5'd2, 5'd0, 5'd0, 32'(n + 3), 1'b1,
                    (32'(n + 3) << 20) | 32'h113, 32'h0C + 32'(4 * n));
      checkOutput("pp_count_hold", {61'd0, oCount}, 64'd2);
    end
    idle();
    waitDrain();

    $display("[TB] reset mid-burst");
    iReady = 1'b0;
    applyStimulus(INST_ADDI, 5'd4, 5'd0, 5'd0, 32'd1, 1'b1, 32'h0010_0213, 32'h34);
    applyStimulus(INST_ADDI, 5'd4, 5'd0, 5'd0, 32'd2, 1'b1, 32'h0020_0213, 32'h38);
    applyStimulus(INST_ADDI, 5'd4, 5'd0, 5'd0, 32'd3, 1'b1, 32'h0030_0213, 32'h3C);
    idle();
    checkOutput("mid_count_before", {61'd0, oCount}, 64'd3);
    resetDut();
    checkOutput("mid_valid_after", {63'd0, oValid}, 64'd0);
    checkOutput("mid_count_after", {61'd0, oCount}, 64'd0);
    iReady = 1'b1;
    applyStimulus(INST_ADDI, 5'd7, 5'd0, 5'd0, 32'd1, 1'b1, 32'h0010_0393, 32'h0);
    idle();
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
